// File: rtl/sync_fifo_stream_reader_if.sv
// Stream-reader bus bundle: FIFO read port, flush control and valid/ready stream output.
//   master : the reader (consumes FIFO status/data, flush, ready; drives read, valid, data)
//   slave  : the FIFO + downstream side (mirror of master)
interface sync_fifo_stream_reader_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  fifo_empty_i;
  logic [DATA_WIDTH-1:0] fifo_rd_data_i;
  logic                  fifo_read_o;
  logic                  flush_i;
  logic                  m_valid_o;
  logic [DATA_WIDTH-1:0] m_data_o;
  logic                  m_ready_i;

  modport master (
    input  fifo_empty_i, fifo_rd_data_i, flush_i, m_ready_i,
    output fifo_read_o, m_valid_o, m_data_o
  );

  modport slave (
    output fifo_empty_i, fifo_rd_data_i, flush_i, m_ready_i,
    input  fifo_read_o, m_valid_o, m_data_o
  );
endinterface

// File: rtl/sync_fifo_stream_reader.sv
// Read-side master for a synchronous FIFO. Pulls words from the FIFO read port and
// presents them on a valid/ready stream through a 2-entry registered skid buffer,
// absorbing 0-cycle (FWFT) or 1-cycle (standard) FIFO read latency.
// Ports:
//   clk_i        clock
//   rst_n_i      synchronous active-low reset
//   bus          master modport: fifo_empty_i, fifo_rd_data_i, fifo_read_o,
//                flush_i, m_valid_o, m_data_o, m_ready_i
//   word_count_o pops since reset (only with SYNC_FIFO_STREAM_READER_COUNT_EN defined)
// Optional feature macro: SYNC_FIFO_STREAM_READER_COUNT_EN
module sync_fifo_stream_reader #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter bit          FWFT       = 1'b1
) (
  input  logic                      clk_i,
  input  logic                      rst_n_i,
  sync_fifo_stream_reader_if.master bus
`ifdef SYNC_FIFO_STREAM_READER_COUNT_EN
  ,
  output logic [31:0]               word_count_o
`endif
);

  localparam int unsigned OCC_W = 2;
  localparam int unsigned LVL_W = 3;

  logic [OCC_W-1:0]      occ_q, occ_d;
  logic                  inflight_q, inflight_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] e0_q, e0_d;
  logic [DATA_WIDTH-1:0] e1_q, e1_d;

  logic                  pop;
  logic                  read_c;
  logic                  capture;
  logic [OCC_W-1:0]      occ_after_pop;
  logic [LVL_W-1:0]      level;

  // Handshake and read issue; ready feeds the read decision combinationally for full rate.
  assign pop           = valid_q & bus.m_ready_i;
  assign level         = LVL_W'(occ_q) + LVL_W'(inflight_q) - LVL_W'(pop);
  assign read_c        = rst_n_i & ~bus.flush_i & ~bus.fifo_empty_i & (level < LVL_W'(2));
  assign capture       = FWFT ? read_c : inflight_q;
  assign occ_after_pop = occ_q - OCC_W'(pop);

  // Skid buffer next state: pop shifts e1->e0, capture lands in the first free slot after the pop.
  always_comb begin
    occ_d      = occ_q;
    inflight_d = inflight_q;
    valid_d    = valid_q;
    e0_d       = e0_q;
    e1_d       = e1_q;
    if (bus.flush_i) begin
      occ_d      = '0;
      inflight_d = 1'b0;
      valid_d    = 1'b0;
    end else begin
      if (pop) begin
        e0_d = e1_q;
      end
      if (capture) begin
        if (occ_after_pop == '0) begin
          e0_d = bus.fifo_rd_data_i;
        end else begin
          e1_d = bus.fifo_rd_data_i;
        end
      end
      occ_d      = occ_after_pop + OCC_W'(capture);
      inflight_d = FWFT ? 1'b0 : read_c;
      valid_d    = (occ_d != '0);
    end
  end

  // State registers.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      occ_q      <= '0;
      inflight_q <= 1'b0;
      valid_q    <= 1'b0;
      e0_q       <= '0;
      e1_q       <= '0;
    end else begin
      occ_q      <= occ_d;
      inflight_q <= inflight_d;
      valid_q    <= valid_d;
      e0_q       <= e0_d;
      e1_q       <= e1_d;
    end
  end

  assign bus.fifo_read_o = read_c;
  assign bus.m_valid_o   = valid_q;
  assign bus.m_data_o    = e0_q;

`ifdef SYNC_FIFO_STREAM_READER_COUNT_EN
  localparam int unsigned CNT_W = 32;

  logic [CNT_W-1:0] count_q;

  // Completed handshakes since reset; flush does not clear it, wraps naturally.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      count_q <= '0;
    end else if (pop) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign word_count_o = count_q;
`endif

endmodule
